// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types and constants for the MEM stage: pipeline
//                register structs, MEM FSM states, load/store encodings and
//                writeback mux select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    // Load funct3 encodings
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] c_size_b = 2'b00;
    localparam logic [1:0] c_size_h = 2'b01;
    localparam logic [1:0] c_size_w = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [2:0] {
        RF_ALU_OUT = 3'd0,
        RF_LB      = 3'd1,
        RF_LBU     = 3'd2,
        RF_LH      = 3'd3,
        RF_LHU     = 3'd4,
        RF_LW      = 3'd5
    } regfilemux_sel_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_addr;
        logic        regf_we;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic [31:0]     inst;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [4:0]      rd_addr;
        logic            regf_we;
        logic [31:0]     alu_out;
        logic [31:0]     dmem_addr;
        logic [3:0]      dmem_rmask;
        logic [3:0]      dmem_wmask;
        logic [31:0]     dmem_wdata;
        regfilemux_sel_t regfilemux_sel;
    } mem_wb_stage_reg_t;

    // Writeback source: loads pick their extension flavour, everything else ALU
    function automatic regfilemux_sel_t rfmux_sel(input logic [6:0] opcode,
                                                  input logic [2:0] funct3);
        rfmux_sel = RF_ALU_OUT;
        if (opcode == c_op_load) begin
            case (funct3)
                c_f3_lb:  rfmux_sel = RF_LB;
                c_f3_lbu: rfmux_sel = RF_LBU;
                c_f3_lh:  rfmux_sel = RF_LH;
                c_f3_lhu: rfmux_sel = RF_LHU;
                c_f3_lw:  rfmux_sel = RF_LW;
                default:  rfmux_sel = RF_ALU_OUT;
            endcase
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mem_mask_gen
//  Description : Combinational byte-lane mask, store data lane shift and
//                misalignment detection for a single data memory access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_mask_gen
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2_v,
    input  logic        is_load,
    input  logic        is_store,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [3:0] w_mask;

    // Lane mask by access size; size encoding 2'b11 is illegal and never issues
    always_comb begin
        w_mask     = 4'b0000;
        misaligned = 1'b0;
        case (funct3[1:0])
            c_size_b: w_mask = 4'b0001 << off;
            c_size_h: begin
                w_mask     = 4'b0011 << off;
                misaligned = off[0];
            end
            c_size_w: begin
                w_mask     = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default:  misaligned = 1'b1;
        endcase
        rmask = is_load  ? w_mask : 4'b0000;
        wmask = is_store ? w_mask : 4'b0000;
        wdata = rs2_v << {off, 3'b000};
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Issues one data memory request per
//                load/store, registers MEM/WB, and freezes the pipeline while
//                the access held in MEM/WB waits for its response.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_stage_reg_t ex_mem,
    input  logic              flush,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_resp,
    output mem_wb_stage_reg_t mem_wb,
    output logic              freeze_stall,
    output logic              flush_delayed,
    output logic              dmem_timeout
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    mem_wb_stage_reg_t r_mem_wb;
    logic              r_flush_pending;
    logic              r_flush_delayed;
    logic              r_dmem_timeout;
    logic [c_cnt_w-1:0] r_wait_cnt;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_kill;
    logic        w_issue;
    logic        w_misaligned;
    logic [3:0]  w_mg_rmask;
    logic [3:0]  w_mg_wmask;
    logic [31:0] w_mg_wdata;

    assign w_is_load  = (ex_mem.opcode == c_op_load);
    assign w_is_store = (ex_mem.opcode == c_op_store);
    assign w_kill     = flush | r_flush_pending;
    assign dmem_addr  = {ex_mem.alu_out[31:2], 2'b00};

    mem_mask_gen u_mask_gen (
        .funct3     (ex_mem.funct3),
        .off        (ex_mem.alu_out[1:0]),
        .rs2_v      (ex_mem.rs2_v),
        .is_load    (w_is_load),
        .is_store   (w_is_store),
        .rmask      (w_mg_rmask),
        .wmask      (w_mg_wmask),
        .wdata      (w_mg_wdata),
        .misaligned (w_misaligned)
    );

    // Request issue, stall generation and next-state logic; rst suppresses
    // requests so nothing is driven while the stage is held in reset
    always_comb begin
        w_state_next = r_state;
        freeze_stall = (r_state == WAIT) && !dmem_resp;
        w_issue      = !rst && ex_mem.valid && (w_is_load || w_is_store) &&
                       !w_kill && !freeze_stall && !w_misaligned;
        dmem_rmask   = w_issue ? w_mg_rmask : 4'b0000;
        dmem_wmask   = w_issue ? w_mg_wmask : 4'b0000;
        dmem_wdata   = (w_issue && w_is_store) ? w_mg_wdata : 32'h0;
        case (r_state)
            IDLE:    if (w_issue) w_state_next = WAIT;
            WAIT:    if (dmem_resp && !w_issue) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // MEM/WB register: held while frozen, otherwise captures ex_mem
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_wb <= '0;
        end else if (!freeze_stall) begin
            r_mem_wb.valid          <= ex_mem.valid && !w_kill;
            r_mem_wb.pc             <= ex_mem.pc;
            r_mem_wb.inst           <= ex_mem.inst;
            r_mem_wb.opcode         <= ex_mem.opcode;
            r_mem_wb.funct3         <= ex_mem.funct3;
            r_mem_wb.rd_addr        <= ex_mem.rd_addr;
            r_mem_wb.regf_we        <= ex_mem.regf_we;
            r_mem_wb.alu_out        <= ex_mem.alu_out;
            r_mem_wb.dmem_addr      <= dmem_addr;
            r_mem_wb.dmem_rmask     <= dmem_rmask;
            r_mem_wb.dmem_wmask     <= dmem_wmask;
            r_mem_wb.dmem_wdata     <= dmem_wdata;
            r_mem_wb.regfilemux_sel <= rfmux_sel(ex_mem.opcode, ex_mem.funct3);
        end
    end

    // A flush seen while frozen targets the instruction held upstream, so it
    // is remembered until the next unfrozen edge turns that slot into a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_flush_pending <= 1'b0;
        else if (freeze_stall) r_flush_pending <= r_flush_pending | flush;
        else                   r_flush_pending <= 1'b0;
    end

    // Flush delayed by one cycle, independent of freeze
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_flush_delayed <= 1'b0;
        else     r_flush_delayed <= flush;
    end

    // Wait-cycle counter for the access in flight (restarts for each access,
    // saturates rather than wrapping)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (freeze_stall) begin
            if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Sticky timeout: set when the last allowed wait cycle also goes unanswered
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dmem_timeout <= 1'b0;
        else if (freeze_stall && (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)))
            r_dmem_timeout <= 1'b1;
    end

    assign mem_wb        = r_mem_wb;
    assign flush_delayed = r_flush_delayed;
    assign dmem_timeout  = r_dmem_timeout;

endmodule
`default_nettype wire
